decode_stage: RTL and testbench

//  RV32I decode stage: sits directly downstream of fetch, consuming its instr/pc each cycle.

---
 rtl/riscv_pkg.sv | 61 ++++++
 rtl/decode_stage_reg_file.sv | 51 +++++
 rtl/decode_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations, immediate formats,
// the control word layout and the canonical NOP.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  // Bit order matches the id_ctrl port: {reg_we, mem_rd, mem_wr, branch, jal, jalr}
  typedef struct packed {
    logic regWe;
    logic memRd;
    logic memWr;
    logic branch;
    logic jal;
    logic jalr;
  } ctrl_t;

  function automatic logic [31:0] immGen(input logic [31:0] instr, input imm_type_e kind);
    logic [31:0] imm;
    case (kind)
      IMM_S:   imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{21{instr[31]}}, instr[30:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Two-read, one-write architectural register file with x0 tied to zero and
// write-to-read bypass so a same-cycle writeback is visible to decode.
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            we_i,
  input  logic [4:0]      wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wrEn;

  assign wrEn = we_i && (wr_addr_i != 5'd0);

  // Contents are deliberately not reset; software initialises registers it uses.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rs1_data_o = '0;
    if (rs1_i == 5'd0) begin
      rs1_data_o = '0;
    end else if (wrEn && (wr_addr_i == rs1_i)) begin
      rs1_data_o = wr_data_i;
    end else begin
      rs1_data_o = regs_q[rs1_i];
    end
  end

  always_comb begin
    rs2_data_o = '0;
    if (rs2_i == 5'd0) begin
      rs2_data_o = '0;
    end else if (wrEn && (wr_addr_i == rs2_i)) begin
      rs2_data_o = wr_data_i;
    end else begin
      rs2_data_o = regs_q[rs2_i];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, register-file read, immediate and control
// generation, load-use stall and flush handling, registered ID/EX bundle.
module decode_stage #(
  parameter int          XLEN      = 32,
  parameter int          NREGS     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_o,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_rs1_data,
  output logic [XLEN-1:0] id_rs2_data,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [3:0]      id_alu_op,
  output logic [1:0]      id_alu_src,
  output logic [5:0]      id_ctrl,
  output logic [2:0]      id_funct3,
  output logic            id_illegal
);

  import riscv_pkg::*;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    alu_op_e         aluOp;
    logic [1:0]      aluSrc;
    ctrl_t           ctrl;
    logic [2:0]      funct3;
    logic            illegal;
  } idex_t;

  logic [31:0]     ifInstr_q, ifInstr_d;
  logic [XLEN-1:0] ifPc_q, ifPc_d;
  logic            ifValid_q, ifValid_d;
  idex_t           idEx_q, idEx_d;

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [XLEN-1:0] rs1Data, rs2Data;

  logic            usesRs1, usesRs2, illegal, hazard;
  imm_type_e       immType;
  alu_op_e         aluOp, funcOp;
  logic [1:0]      aluSrc;
  ctrl_t           ctrl;

  assign opcode   = ifInstr_q[6:0];
  assign rd       = ifInstr_q[11:7];
  assign funct3   = ifInstr_q[14:12];
  assign rs1      = ifInstr_q[19:15];
  assign rs2      = ifInstr_q[24:20];
  assign funct7b5 = ifInstr_q[30];

  reg_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_reg_file (
    .clk        (clk),
    .rs1_i      (rs1),
    .rs2_i      (rs2),
    .rs1_data_o (rs1Data),
    .rs2_data_o (rs2Data),
    .we_i       (wb_we),
    .wr_addr_i  (wb_rd),
    .wr_data_i  (wb_data)
  );

  // funct3 selects the ALU operation for OP and OP-IMM; bit 30 picks SRA over SRL.
  always_comb begin
    funcOp = ALU_ADD;
    case (funct3)
      3'b000:  funcOp = ALU_ADD;
      3'b001:  funcOp = ALU_SLL;
      3'b010:  funcOp = ALU_SLT;
      3'b011:  funcOp = ALU_SLTU;
      3'b100:  funcOp = ALU_XOR;
      3'b101:  funcOp = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  funcOp = ALU_OR;
      default: funcOp = ALU_AND;
    endcase
  end

  always_comb begin
    usesRs1 = 1'b1;
    usesRs2 = 1'b0;
    illegal = 1'b0;
    immType = IMM_I;
    aluOp   = ALU_ADD;
    aluSrc  = 2'b00;
    ctrl    = '0;
    case (opcode)
      OPC_LUI: begin
        usesRs1    = 1'b0;
        immType    = IMM_U;
        aluOp      = ALU_PASSB;
        aluSrc     = 2'b01;
        ctrl.regWe = 1'b1;
      end
      OPC_AUIPC: begin
        usesRs1    = 1'b0;
        immType    = IMM_U;
        aluSrc     = 2'b11;
        ctrl.regWe = 1'b1;
      end
      OPC_JAL: begin
        usesRs1    = 1'b0;
        immType    = IMM_J;
        aluSrc     = 2'b11;
        ctrl.regWe = 1'b1;
        ctrl.jal   = 1'b1;
      end
      OPC_JALR: begin
        aluSrc     = 2'b01;
        ctrl.regWe = 1'b1;
        ctrl.jalr  = 1'b1;
      end
      OPC_BRANCH: begin
        usesRs2     = 1'b1;
        immType     = IMM_B;
        aluOp       = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      OPC_LOAD: begin
        aluSrc     = 2'b01;
        ctrl.regWe = 1'b1;
        ctrl.memRd = 1'b1;
      end
      OPC_STORE: begin
        usesRs2    = 1'b1;
        immType    = IMM_S;
        aluSrc     = 2'b01;
        ctrl.memWr = 1'b1;
      end
      OPC_OP_IMM: begin
        aluOp      = funcOp;
        aluSrc     = 2'b01;
        ctrl.regWe = 1'b1;
      end
      OPC_OP: begin
        usesRs2    = 1'b1;
        aluOp      = ((funct3 == 3'b000) && funct7b5) ? ALU_SUB : funcOp;
        ctrl.regWe = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign hazard  = ex_mem_read && (ex_rd != 5'd0) &&
                   ((usesRs1 && (rs1 == ex_rd)) || (usesRs2 && (rs2 == ex_rd)));
  assign stall_o = hazard && !flush;

  always_comb begin
    ifInstr_d = ifInstr_q;
    ifPc_d    = ifPc_q;
    ifValid_d = ifValid_q;
    if (flush) begin
      ifInstr_d = NOP_INSTR;
      ifValid_d = 1'b0;
    end else if (!hazard) begin
      ifInstr_d = if_instr;
      ifPc_d    = if_pc;
      ifValid_d = 1'b1;
    end
  end

  // A bubble is an all-zero bundle, so nothing stale leaks into execute.
  always_comb begin
    idEx_d = '0;
    if (!flush && !hazard && ifValid_q) begin
      idEx_d.valid   = 1'b1;
      idEx_d.pc      = ifPc_q;
      idEx_d.rs1Data = rs1Data;
      idEx_d.rs2Data = rs2Data;
      idEx_d.imm     = immGen(ifInstr_q, immType);
      idEx_d.rs1     = rs1;
      idEx_d.rs2     = rs2;
      idEx_d.rd      = rd;
      idEx_d.aluOp   = aluOp;
      idEx_d.aluSrc  = aluSrc;
      idEx_d.ctrl    = illegal ? '0 : ctrl;
      idEx_d.funct3  = funct3;
      idEx_d.illegal = illegal;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifInstr_q <= NOP_INSTR;
      ifPc_q    <= '0;
      ifValid_q <= 1'b0;
      idEx_q    <= '0;
    end else begin
      ifInstr_q <= ifInstr_d;
      ifPc_q    <= ifPc_d;
      ifValid_q <= ifValid_d;
      idEx_q    <= idEx_d;
    end
  end

  assign id_valid    = idEx_q.valid;
  assign id_pc       = idEx_q.pc;
  assign id_rs1_data = idEx_q.rs1Data;
  assign id_rs2_data = idEx_q.rs2Data;
  assign id_imm      = idEx_q.imm;
  assign id_rs1      = idEx_q.rs1;
  assign id_rs2      = idEx_q.rs2;
  assign id_rd       = idEx_q.rd;
  assign id_alu_op   = idEx_q.aluOp;
  assign id_alu_src  = idEx_q.aluSrc;
  assign id_ctrl     = idEx_q.ctrl;
  assign id_funct3   = idEx_q.funct3;
  assign id_illegal  = idEx_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table-driven decode vectors checked
// through a latency scoreboard, plus hand sequences for bypass, stall, flush and reset.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] if_instr, if_pc;
  logic        flush, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall_o, id_valid, id_illegal;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_alu_src;
  logic [5:0]  id_ctrl;
  logic [2:0]  id_funct3;

  decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .flush       (flush),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .stall_o     (stall_o),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_rs1_data (id_rs1_data),
    .id_rs2_data (id_rs2_data),
    .id_imm      (id_imm),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_alu_op   (id_alu_op),
    .id_alu_src  (id_alu_src),
    .id_ctrl     (id_ctrl),
    .id_funct3   (id_funct3),
    .id_illegal  (id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        expIllegal;
    logic [5:0]  expCtrl;
    logic [4:0]  expRd;
    logic        chkImm;
    logic [31:0] expImm;
    logic [3:0]  expAluOp;
    logic [1:0]  expAluSrc;
  } vec_t;

  typedef struct {
    vec_t v;
    int   idx;
    int   due;
  } sb_t;

  localparam int NVEC = 14;
  localparam logic [31:0] NOP = 32'h00000013;

  vec_t vecs [NVEC];
  sb_t  sbq [$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic ill, input logic [5:0] ctrl, input logic [4:0] rd,
                              input logic chkImm, input logic [31:0] imm,
                              input logic [3:0] alu, input logic [1:0] src);
    vec_t v;
    v.instr = instr; v.pc = pc; v.expIllegal = ill; v.expCtrl = ctrl; v.expRd = rd;
    v.chkImm = chkImm; v.expImm = imm; v.expAluOp = alu; v.expAluSrc = src;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc);
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic checkScoreboard();
    sb_t e;
    while (sbq.size() > 0 && sbq[0].due <= cycle) begin
      e = sbq.pop_front();
      checkOutput($sformatf("v%0d.valid", e.idx), 32'(id_valid), 32'd1);
      checkOutput($sformatf("v%0d.pc", e.idx), id_pc, e.v.pc);
      checkOutput($sformatf("v%0d.illegal", e.idx), 32'(id_illegal), 32'(e.v.expIllegal));
      checkOutput($sformatf("v%0d.ctrl", e.idx), 32'(id_ctrl), 32'(e.v.expCtrl));
      if (e.v.expCtrl[5])
        checkOutput($sformatf("v%0d.rd", e.idx), 32'(id_rd), 32'(e.v.expRd));
      if (!e.v.expIllegal) begin
        checkOutput($sformatf("v%0d.aluOp", e.idx), 32'(id_alu_op), 32'(e.v.expAluOp));
        checkOutput($sformatf("v%0d.aluSrc", e.idx), 32'(id_alu_src), 32'(e.v.expAluSrc));
      end
      if (e.v.chkImm)
        checkOutput($sformatf("v%0d.imm", e.idx), id_imm, e.v.expImm);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = mk(32'h00500093, 32'h00, 1'b0, 6'h20, 5'd1,  1'b1, 32'h00000005, 4'd0,  2'b01);
    vecs[1]  = mk(32'hFE000EE3, 32'h04, 1'b0, 6'h04, 5'd0,  1'b1, 32'hFFFFFFFC, 4'd1,  2'b00);
    vecs[2]  = mk(32'h001000EF, 32'h08, 1'b0, 6'h22, 5'd1,  1'b1, 32'h00000800, 4'd0,  2'b11);
    vecs[3]  = mk(32'hABCDE2B7, 32'h0C, 1'b0, 6'h20, 5'd5,  1'b1, 32'hABCDE000, 4'd10, 2'b01);
    vecs[4]  = mk(32'hFE21AC23, 32'h10, 1'b0, 6'h08, 5'd0,  1'b1, 32'hFFFFFFF8, 4'd0,  2'b01);
    vecs[5]  = mk(32'h00C0A303, 32'h14, 1'b0, 6'h30, 5'd6,  1'b1, 32'h0000000C, 4'd0,  2'b01);
    vecs[6]  = mk(32'h402083B3, 32'h18, 1'b0, 6'h20, 5'd7,  1'b0, 32'h0,        4'd1,  2'b00);
    vecs[7]  = mk(32'h4030D413, 32'h1C, 1'b0, 6'h20, 5'd8,  1'b1, 32'h00000403, 4'd7,  2'b01);
    vecs[8]  = mk(32'h12345497, 32'h20, 1'b0, 6'h20, 5'd9,  1'b1, 32'h12345000, 4'd0,  2'b11);
    vecs[9]  = mk(32'h000280E7, 32'h24, 1'b0, 6'h21, 5'd1,  1'b1, 32'h00000000, 4'd0,  2'b01);
    vecs[10] = mk(32'h0000007F, 32'h28, 1'b1, 6'h00, 5'd0,  1'b0, 32'h0,        4'd0,  2'b00);
    vecs[11] = mk(32'h0020C533, 32'h2C, 1'b0, 6'h20, 5'd10, 1'b0, 32'h0,        4'd5,  2'b00);
    vecs[12] = mk(32'h00000073, 32'h30, 1'b1, 6'h00, 5'd0,  1'b0, 32'h0,        4'd0,  2'b00);
    vecs[13] = mk(32'hFFF00093, 32'h34, 1'b0, 6'h20, 5'd1,  1'b1, 32'hFFFFFFFF, 4'd0,  2'b01);

    rst = 1'b1; flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    applyStimulus(NOP, 32'h0);
    #2 rst = 1'b0;
    step(); step();
    $display("[TB] reset state");
    checkOutput("rst.valid", 32'(id_valid), 32'd0);
    checkOutput("rst.pc", id_pc, 32'd0);
    checkOutput("rst.imm", id_imm, 32'd0);
    checkOutput("rst.ctrl", 32'(id_ctrl), 32'd0);
    checkOutput("rst.illegal", 32'(id_illegal), 32'd0);
    checkOutput("rst.aluOp", 32'(id_alu_op), 32'd0);
    checkOutput("rst.stall", 32'(stall_o), 32'd0);
    rst = 1'b1;

    $display("[TB] first instruction latency");
    applyStimulus(32'h00500093, 32'h0);
    step();
    applyStimulus(NOP, 32'h4);
    checkOutput("t1.notYet", 32'(id_valid), 32'd0);
    step();
    checkOutput("t1.valid", 32'(id_valid), 32'd1);
    checkOutput("t1.rd", 32'(id_rd), 32'd1);
    checkOutput("t1.imm", id_imm, 32'd5);
    checkOutput("t1.aluOp", 32'(id_alu_op), 32'd0);
    checkOutput("t1.ctrl", 32'(id_ctrl), 32'h20);
    checkOutput("t1.illegal", 32'(id_illegal), 32'd0);

    $display("[TB] decode table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].pc);
      sbq.push_back('{v: vecs[i], idx: i, due: cycle + 2});
      step();
      checkScoreboard();
    end
    applyStimulus(NOP, 32'h80);
    for (int k = 0; k < 8 && sbq.size() > 0; k++) begin
      step();
      checkScoreboard();
    end
    checkOutput("sb.drained", 32'(sbq.size()), 32'd0);

    $display("[TB] register file bypass and x0");
    applyStimulus(32'h00018233, 32'h100);
    step();
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    applyStimulus(NOP, 32'h104);
    step();
    wb_we = 1'b0;
    checkOutput("t2.bypass", id_rs1_data, 32'hDEADBEEF);
    checkOutput("t2.rs2x0", id_rs2_data, 32'h0);
    applyStimulus(32'h00018233, 32'h108);
    step(); step();
    checkOutput("t2.stored", id_rs1_data, 32'hDEADBEEF);
    applyStimulus(32'h00000233, 32'h10C);
    step();
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
    ex_mem_read = 1'b1; ex_rd = 5'd0;
    #1;
    checkOutput("t2.exRdZero", 32'(stall_o), 32'd0);
    step();
    wb_we = 1'b0; ex_mem_read = 1'b0;
    checkOutput("t2.x0bypass", id_rs1_data, 32'h0);
    step();
    checkOutput("t2.x0read", id_rs1_data, 32'h0);

    $display("[TB] load-use stall");
    applyStimulus(32'h001102B3, 32'h200);
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    applyStimulus(32'h00500093, 32'h204);
    #1;
    checkOutput("t3.stall", 32'(stall_o), 32'd1);
    step();
    checkOutput("t3.bubble", 32'(id_valid), 32'd0);
    checkOutput("t3.bubbleCtrl", 32'(id_ctrl), 32'd0);
    ex_mem_read = 1'b0;
    #1;
    checkOutput("t3.release", 32'(stall_o), 32'd0);
    step();
    checkOutput("t3.issueValid", 32'(id_valid), 32'd1);
    checkOutput("t3.issuePc", id_pc, 32'h200);
    checkOutput("t3.issueRd", 32'(id_rd), 32'd5);
    step();
    checkOutput("t3.nextPc", id_pc, 32'h204);
    checkOutput("t3.nextRd", 32'(id_rd), 32'd1);

    $display("[TB] rs usage boundaries");
    applyStimulus(32'hABCDE2B7, 32'h240);
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd27;
    #1;
    checkOutput("t3.luiNoRs1", 32'(stall_o), 32'd0);
    ex_mem_read = 1'b0;
    applyStimulus(32'hFE21AC23, 32'h244);
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    #1;
    checkOutput("t3.storeRs2", 32'(stall_o), 32'd1);
    ex_mem_read = 1'b0;
    step();

    $display("[TB] flush over stall");
    applyStimulus(32'h001102B3, 32'h300);
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd2; flush = 1'b1;
    applyStimulus(32'h0000007F, 32'h304);
    #1;
    checkOutput("t4.stallMasked", 32'(stall_o), 32'd0);
    step();
    checkOutput("t4.bubble", 32'(id_valid), 32'd0);
    flush = 1'b0;
    applyStimulus(32'h0020C533, 32'h400);
    #1;
    checkOutput("t4.nopNoStall", 32'(stall_o), 32'd0);
    step();
    ex_mem_read = 1'b0;
    checkOutput("t4.ifidInvalid", 32'(id_valid), 32'd0);
    checkOutput("t4.noIllegal", 32'(id_illegal), 32'd0);
    step();
    checkOutput("t4.targetValid", 32'(id_valid), 32'd1);
    checkOutput("t4.targetPc", id_pc, 32'h400);
    checkOutput("t4.targetRd", 32'(id_rd), 32'd10);

    $display("[TB] reset mid-stream");
    applyStimulus(32'h00500093, 32'h500);
    step();
    applyStimulus(32'h001102B3, 32'h504);
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd2;
    #1;
    checkOutput("t6.preStall", 32'(stall_o), 32'd1);
    checkOutput("t6.preValid", 32'(id_valid), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("t6.valid", 32'(id_valid), 32'd0);
    checkOutput("t6.pc", id_pc, 32'd0);
    checkOutput("t6.imm", id_imm, 32'd0);
    checkOutput("t6.rd", 32'(id_rd), 32'd0);
    checkOutput("t6.ctrl", 32'(id_ctrl), 32'd0);
    checkOutput("t6.stall", 32'(stall_o), 32'd0);
    #1;
    rst = 1'b1;
    ex_mem_read = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
